// File: rtl/fcc_pkg.sv
// ---------------------------------------------------------------------------
// fcc_pkg
// Shared definitions for the fault coverage collector:
//   - block geometry (fault copies, outputs per copy, vector width)
//   - derived count widths (CNT_W for per-fault counts, BEST_W for hit counts)
//   - collector FSM state enum
//   - helper that extracts one faulty copy's response from the packed bus
// ---------------------------------------------------------------------------
package fcc_pkg;

  localparam int NUM_FAULTS = 6;
  localparam int NUM_OUTS   = 2;
  localparam int VEC_W      = 4;
  localparam int RESP_W     = NUM_FAULTS * NUM_OUTS;
  localparam int CNT_W      = VEC_W + 1;
  localparam int BEST_W     = $clog2(NUM_FAULTS + 1);

  // One sweep applies 2^VEC_W vectors, so a per-fault count tops out there.
  localparam logic [CNT_W-1:0] CNT_MAX   = {1'b1, {VEC_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [VEC_W-1:0] VEC_ONE   = {{(VEC_W-1){1'b0}}, 1'b1};
  localparam logic [VEC_W-1:0] LAST_BEAT = {VEC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } fcc_state_e;

  // Response of faulty copy idx; copy idx occupies [idx*NUM_OUTS +: NUM_OUTS].
  function automatic logic [NUM_OUTS-1:0] fault_slice(
    input logic [RESP_W-1:0] resp,
    input int unsigned       idx
  );
    return resp[idx*NUM_OUTS +: NUM_OUTS];
  endfunction

endpackage

// File: rtl/fcc_popcount.sv
// ---------------------------------------------------------------------------
// fcc_popcount
// Combinational population count of the per-fault difference vector; gives
// the number of faults a single test vector detects.
// Ports:
//   bits_i   [NUM_FAULTS-1:0]  one bit per fault copy, set when it differs
//   count_o  [BEST_W-1:0]      number of set bits
// ---------------------------------------------------------------------------
module fcc_popcount
  import fcc_pkg::*;
(
  input  logic [NUM_FAULTS-1:0] bits_i,
  output logic [BEST_W-1:0]     count_o
);

  // Ripple sum of the difference bits.
  always_comb begin
    count_o = {BEST_W{1'b0}};
    for (int i = 0; i < NUM_FAULTS; i++) begin
      count_o = count_o + BEST_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/fault_coverage_collector.sv
// ---------------------------------------------------------------------------
// fault_coverage_collector
// Response side of an exhaustive stuck-at fault sweep. Each accepted beat
// carries the fault-free outputs and the outputs of every faulty copy for
// one applied vector. Over the sweep the block accumulates which faults were
// detected, how many vectors detected each fault, (optionally) the first
// detecting vector per fault, and the vector detecting the most faults.
//
// Build option: FCC_FIRST_VEC_EN -- when defined, first-detecting-vector
// registers are built; otherwise first_vec is tied to zero.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a sweep (honoured in IDLE or DONE only)
//   in_valid        beat valid; in_ready high only while collecting
//   in_vec          vector applied this beat (checked against beat index)
//   good_resp       fault-free outputs
//   fault_resp      faulty outputs, copy i at [i*NUM_OUTS +: NUM_OUTS]
//   busy, done      collecting / sweep finished (done held until start/rst)
//   seq_err         sticky: some in_vec differed from the expected index
//   detected_mask   bit i set once fault i is detected
//   det_count       per-fault detecting-vector count, CNT_W bits each
//   first_vec       per-fault first detecting vector, VEC_W bits each
//   best_vec        vector detecting the most faults (ties -> later vector)
//   best_count      number of faults detected by best_vec
// ---------------------------------------------------------------------------
module fault_coverage_collector
  import fcc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [VEC_W-1:0]            in_vec,
  input  logic [NUM_OUTS-1:0]         good_resp,
  input  logic [RESP_W-1:0]           fault_resp,
  output logic                        busy,
  output logic                        done,
  output logic                        seq_err,
  output logic [NUM_FAULTS-1:0]       detected_mask,
  output logic [NUM_FAULTS*CNT_W-1:0] det_count,
  output logic [NUM_FAULTS*VEC_W-1:0] first_vec,
  output logic [VEC_W-1:0]            best_vec,
  output logic [BEST_W-1:0]           best_count
);

  fcc_state_e                         state_q, state_d;
  logic [VEC_W-1:0]                   beat_q, beat_d;
  logic                               seq_err_q, seq_err_d;
  logic [NUM_FAULTS-1:0]              mask_q, mask_d;
  logic [NUM_FAULTS-1:0][CNT_W-1:0]   det_q, det_d;
  logic [VEC_W-1:0]                   best_vec_q, best_vec_d;
  logic [BEST_W-1:0]                  best_cnt_q, best_cnt_d;
`ifdef FCC_FIRST_VEC_EN
  logic [NUM_FAULTS-1:0][VEC_W-1:0]   first_q, first_d;
`endif

  logic                               accept_s;
  logic [NUM_FAULTS-1:0]              diff_s;
  logic [BEST_W-1:0]                  hits_s;

  // Per-fault detection: any output bit differing from the fault-free copy.
  always_comb begin
    diff_s = {NUM_FAULTS{1'b0}};
    for (int i = 0; i < NUM_FAULTS; i++) begin
      diff_s[i] = |(good_resp ^ fault_slice(fault_resp, i));
    end
  end

  fcc_popcount u_popcount (
    .bits_i  (diff_s),
    .count_o (hits_s)
  );

  assign accept_s = in_valid && (state_q == COLLECT);

  // Next-state logic for the FSM and all accumulated statistics.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    seq_err_d  = seq_err_q;
    mask_d     = mask_q;
    det_d      = det_q;
    best_vec_d = best_vec_q;
    best_cnt_d = best_cnt_q;
`ifdef FCC_FIRST_VEC_EN
    first_d    = first_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = COLLECT;
          beat_d     = {VEC_W{1'b0}};
          seq_err_d  = 1'b0;
          mask_d     = {NUM_FAULTS{1'b0}};
          det_d      = '0;
          best_vec_d = {VEC_W{1'b0}};
          best_cnt_d = {BEST_W{1'b0}};
`ifdef FCC_FIRST_VEC_EN
          first_d    = '0;
`endif
        end else begin
          state_d = state_q;
        end
      end

      COLLECT: begin
        if (accept_s) begin
          for (int i = 0; i < NUM_FAULTS; i++) begin
            if (diff_s[i]) begin
              mask_d[i] = 1'b1;
`ifdef FCC_FIRST_VEC_EN
              // Only the first detection of a fault records its vector.
              if (!mask_q[i]) begin
                first_d[i] = in_vec;
              end else begin
                first_d[i] = first_q[i];
              end
`endif
              if (det_q[i] != CNT_MAX) begin
                det_d[i] = det_q[i] + CNT_ONE;
              end else begin
                det_d[i] = det_q[i];
              end
            end else begin
              mask_d[i] = mask_q[i];
            end
          end

          // >= so that ties resolve to the later vector.
          if (hits_s >= best_cnt_q) begin
            best_vec_d = in_vec;
            best_cnt_d = hits_s;
          end else begin
            best_vec_d = best_vec_q;
          end

          // Out-of-order vector is flagged but still accumulated.
          if (in_vec != beat_q) begin
            seq_err_d = 1'b1;
          end else begin
            seq_err_d = seq_err_q;
          end

          beat_d = beat_q + VEC_ONE;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= {VEC_W{1'b0}};
      seq_err_q  <= 1'b0;
      mask_q     <= {NUM_FAULTS{1'b0}};
      det_q      <= '0;
      best_vec_q <= {VEC_W{1'b0}};
      best_cnt_q <= {BEST_W{1'b0}};
`ifdef FCC_FIRST_VEC_EN
      first_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      seq_err_q  <= seq_err_d;
      mask_q     <= mask_d;
      det_q      <= det_d;
      best_vec_q <= best_vec_d;
      best_cnt_q <= best_cnt_d;
`ifdef FCC_FIRST_VEC_EN
      first_q    <= first_d;
`endif
    end
  end

  assign in_ready      = (state_q == COLLECT);
  assign busy          = (state_q == COLLECT);
  assign done          = (state_q == DONE);
  assign seq_err       = seq_err_q;
  assign detected_mask = mask_q;
  assign det_count     = det_q;
  assign best_vec      = best_vec_q;
  assign best_count    = best_cnt_q;
`ifdef FCC_FIRST_VEC_EN
  assign first_vec     = first_q;
`else
  assign first_vec     = {(NUM_FAULTS*VEC_W){1'b0}};
`endif

endmodule

// File: tb/tb_fault_coverage_collector.sv
module tb_fault_coverage_collector;

  typedef logic [15:0][5:0] diffs_t;  // diffs[v][f]: fault f differs at vector v

  typedef struct {
    diffs_t      diffs;
    bit          rnd_valid;
    logic [5:0]  exp_mask;
    logic [29:0] exp_det;
    logic [23:0] exp_first;
    logic [3:0]  exp_best;
    logic [2:0]  exp_bcnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready;
  logic [3:0]  in_vec;
  logic [1:0]  good_resp;
  logic [11:0] fault_resp;
  logic        busy, done, seq_err;
  logic [5:0]  detected_mask;
  logic [29:0] det_count;
  logic [23:0] first_vec;
  logic [3:0]  best_vec;
  logic [2:0]  best_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;
  logic [3:0] vec_map [16];

  int exp_det_m [6];
  int exp_first_m [6];
  logic [5:0] exp_mask_m;
  int exp_best_m, exp_bcnt_m;

  vec_t tbl [4];
  diffs_t d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fault_coverage_collector dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .good_resp(good_resp), .fault_resp(fault_resp),
    .busy(busy), .done(done), .seq_err(seq_err), .detected_mask(detected_mask),
    .det_count(det_count), .first_vec(first_vec), .best_vec(best_vec),
    .best_count(best_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: statistics of a whole sweep computed from its diff table.
  task automatic run_model(input diffs_t dd);
    int maxh;
    int h;
    maxh = 0;
    exp_best_m = 0;
    for (int f = 0; f < 6; f++) begin
      exp_det_m[f] = 0;
      exp_first_m[f] = 0;
      for (int v = 0; v < 16; v++) begin
        if (dd[v][f]) begin
          if (exp_det_m[f] == 0) exp_first_m[f] = int'(vec_map[v]);
          exp_det_m[f]++;
        end
      end
      exp_mask_m[f] = (exp_det_m[f] > 0);
    end
    for (int v = 0; v < 16; v++) begin
      h = $countones(dd[v]);
      if (h > maxh) maxh = h;
    end
    for (int v = 0; v < 16; v++) begin
      if ($countones(dd[v]) == maxh) exp_best_m = int'(vec_map[v]);
    end
    exp_bcnt_m = maxh;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mask"}, detected_mask, exp_mask_m);
    for (int f = 0; f < 6; f++) begin
      chk($sformatf("%s_det%0d", tag, f), det_count[f*5 +: 5], exp_det_m[f]);
`ifdef FCC_FIRST_VEC_EN
      chk($sformatf("%s_first%0d", tag, f), first_vec[f*4 +: 4], exp_first_m[f]);
`endif
    end
`ifndef FCC_FIRST_VEC_EN
    chk({tag, "_first_tied"}, first_vec, 0);
`endif
    chk({tag, "_best_vec"}, best_vec, exp_best_m);
    chk({tag, "_best_cnt"}, best_count, exp_bcnt_m);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_mask"}, detected_mask, 0);
    chk({tag, "_det"}, det_count, 0);
    chk({tag, "_first"}, first_vec, 0);
    chk({tag, "_best_vec"}, best_vec, 0);
    chk({tag, "_best_cnt"}, best_count, 0);
  endtask

  // Called at a negedge; pulses start for one edge and returns at the next negedge.
  task automatic do_start();
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Called at a negedge; sends beats first..last, returns at a negedge with in_valid low.
  task automatic send_beats(input diffs_t dd, input int first, input int last, input bit rnd);
    bit acc;
    int guard;
    for (int v = first; v <= last; v++) begin
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_vec = vec_map[v];
        good_resp = 2'($urandom_range(0, 3));
        for (int f = 0; f < 6; f++) begin
          fault_resp[f*2 +: 2] = good_resp ^ (dd[v][f] ? 2'($urandom_range(1, 3)) : 2'b00);
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        @(negedge clk);
        guard++;
        if (!acc && guard > 200) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout: beat %0d not accepted, in_ready %0b expected 1", v, in_ready);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    for (int v = 0; v < 16; v++) vec_map[v] = 4'(v);

    // Directed table.
    tbl[0].diffs = '0; tbl[0].rnd_valid = 1'b0; tbl[0].exp_mask = 6'b000000;
    tbl[0].exp_det = '0; tbl[0].exp_first = '0; tbl[0].exp_best = 4'hF; tbl[0].exp_bcnt = 3'd0;

    tbl[1].diffs = '0; tbl[1].diffs[5] = 6'b000001; tbl[1].rnd_valid = 1'b0;
    tbl[1].exp_mask = 6'b000001; tbl[1].exp_det = '0; tbl[1].exp_det[4:0] = 5'd1;
    tbl[1].exp_first = '0; tbl[1].exp_first[3:0] = 4'd5;
    tbl[1].exp_best = 4'd5; tbl[1].exp_bcnt = 3'd1;

    for (int v = 0; v < 16; v++) tbl[2].diffs[v] = 6'b000100;
    tbl[2].diffs[3] = 6'b010100; tbl[2].diffs[9] = 6'b010100; tbl[2].rnd_valid = 1'b0;
    tbl[2].exp_mask = 6'b010100; tbl[2].exp_det = '0;
    tbl[2].exp_det[14:10] = 5'd16; tbl[2].exp_det[24:20] = 5'd2;
    tbl[2].exp_first = '0; tbl[2].exp_first[19:16] = 4'd3;
    tbl[2].exp_best = 4'd9; tbl[2].exp_bcnt = 3'd2;

    tbl[3] = tbl[2];
    tbl[3].rnd_valid = 1'b1;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = 4'd0;
    good_resp = 2'd0; fault_resp = 12'd0;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    for (int t = 0; t < 4; t++) begin
      do_start();
      chk($sformatf("t%0d_busy", t), busy, 1);
      chk($sformatf("t%0d_in_ready", t), in_ready, 1);
      send_beats(tbl[t].diffs, 0, 14, tbl[t].rnd_valid);
      chk($sformatf("t%0d_done_early", t), done, 0);
      send_beats(tbl[t].diffs, 15, 15, tbl[t].rnd_valid);
      if (!tbl[t].rnd_valid) chk($sformatf("t%0d_latency", t), cyc - start_cyc, 16);
      chk($sformatf("t%0d_done", t), done, 1);
      chk($sformatf("t%0d_mask", t), detected_mask, tbl[t].exp_mask);
      chk($sformatf("t%0d_det", t), det_count, tbl[t].exp_det);
`ifdef FCC_FIRST_VEC_EN
      chk($sformatf("t%0d_first", t), first_vec, tbl[t].exp_first);
`else
      chk($sformatf("t%0d_first", t), first_vec, 0);
`endif
      chk($sformatf("t%0d_best_vec", t), best_vec, tbl[t].exp_best);
      chk($sformatf("t%0d_best_cnt", t), best_count, tbl[t].exp_bcnt);
      chk($sformatf("t%0d_seq_err", t), seq_err, 0);
    end

    // done and results held while idle in DONE.
    repeat (5) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_best_vec", best_vec, 4'd9);

    // Randomized sweeps against the model.
    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 16; v++) d[v] = 6'($urandom) & 6'($urandom);
      run_model(d);
      do_start();
      send_beats(d, 0, 15, 1'b1);
      check_model($sformatf("rnd%0d", r));
    end

    // start in DONE clears statistics on the same edge that raises busy.
    do_start();
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    check_reset_stats: begin
      chk("restart_mask", detected_mask, 0);
      chk("restart_det", det_count, 0);
      chk("restart_best_vec", best_vec, 0);
      chk("restart_best_cnt", best_count, 0);
    end

    // Abort mid-sweep with rst.
    for (int v = 0; v < 16; v++) d[v] = 6'h3F;
    send_beats(d, 0, 6, 1'b0);
    chk("abort_pre_mask", detected_mask, 6'h3F);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset("abort");
    for (int v = 0; v < 16; v++) d[v] = 6'b000010;
    run_model(d);
    do_start();
    send_beats(d, 0, 15, 1'b0);
    check_model("after_abort");
    chk("after_abort_det1", det_count[9:5], 5'd16);

    // Sequence error plus ignored start mid-sweep.
    for (int v = 0; v < 16; v++) vec_map[v] = (v < 3) ? 4'(v) : 4'(v + 1);
    d = '0;
    d[0] = 6'b000001;
    run_model(d);
    do_start();
    send_beats(d, 0, 2, 1'b0);
    chk("seq_err_before", seq_err, 0);
    send_beats(d, 3, 3, 1'b0);
    chk("seq_err_set", seq_err, 1);
    send_beats(d, 4, 5, 1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ign_start_busy", busy, 1);
    chk("ign_start_mask", detected_mask, 6'b000001);
    chk("ign_start_det0", det_count[4:0], 5'd1);
    chk("ign_start_seq_err", seq_err, 1);
    send_beats(d, 6, 15, 1'b0);
    check_model("seq");
    chk("seq_err_final", seq_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
